// File: rtl/memtest_stats.sv
// memtest_stats: run/halt sequencing plus BCD pass/fail counters, BCD mm:ss
// elapsed clock and the underline-mark byte for the status overlay.
module memtest_stats #(
    parameter int CLK_HZ = 14000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        pass_pulse,
    input  logic        fail_pulse,
    output logic [31:0] rez1,
    output logic [31:0] rez2,
    output logic [15:0] elapsed,
    output logic [7:0]  mark,
    output logic        running
);

    // state | meaning
    // IDLE  | after reset, nothing counted yet
    // RUN   | counting events and elapsed time
    // HALT  | results frozen until the next start
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);

    state_t          state;
    state_t          next_state;
    logic [PW-1:0]   presc;
    logic            fail_seen;
    logic            halted;
    logic            counting;
    logic            sec_tick;

    // Eight-digit BCD increment that sticks at 99999999.
    function automatic logic [31:0] bcd_inc(input logic [31:0] v);
        logic [31:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 32'h9999_9999) begin
            for (int i = 0; i < 8; i++) begin
                if (carry) begin
                    if (r[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // mm:ss BCD increment that sticks at 99:59.
    function automatic logic [15:0] time_inc(input logic [15:0] t);
        logic [3:0] mt, mu, st, su;
        {mt, mu, st, su} = t;
        if (t != 16'h9959) begin
            if (su != 4'd9) begin
                su = su + 4'd1;
            end else begin
                su = 4'd0;
                if (st != 4'd5) begin
                    st = st + 4'd1;
                end else begin
                    st = 4'd0;
                    if (mu != 4'd9) begin
                        mu = mu + 4'd1;
                    end else begin
                        mu = 4'd0;
                        mt = mt + 4'd1;
                    end
                end
            end
        end
        return {mt, mu, st, su};
    endfunction

    // A start cycle clears everything, so events in it are dropped.
    assign counting = (state == RUN) && !start;
    assign sec_tick = counting && (presc == PRESC_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start always (re)enters RUN and wins over stop.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = RUN;
            RUN: begin
                if (start) begin
                    next_state = RUN;
                end else if (stop) begin
                    next_state = HALT;
                end
            end
            HALT: if (start) next_state = RUN;
            default: next_state = IDLE;
        endcase
    end

    // Status flags registered alongside the state so they match it exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            running <= 1'b0;
            halted  <= 1'b0;
        end else begin
            running <= (next_state == RUN);
            halted  <= (next_state == HALT);
        end
    end

    // Counters, prescaler, elapsed time and the sticky fail flag.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            rez1      <= '0;
            rez2      <= '0;
            elapsed   <= '0;
            presc     <= '0;
            fail_seen <= 1'b0;
        end else if (counting) begin
            if (pass_pulse) rez1 <= bcd_inc(rez1);
            if (fail_pulse) begin
                rez2      <= bcd_inc(rez2);
                fail_seen <= 1'b1;
            end
            if (sec_tick) begin
                presc   <= '0;
                elapsed <= time_inc(elapsed);
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // Bit 5 blinks under the minutes-units digit during the first half second.
    assign mark = {halted, 1'b0, running && (presc < PRESC_HALF), 4'b0000, fail_seen};

endmodule

// File: tb/tb_memtest_stats.sv
// Directed bench for memtest_stats with a 10-cycle second.
module tb_memtest_stats;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        pass_pulse = 1'b0;
    logic        fail_pulse = 1'b0;
    logic [31:0] rez1;
    logic [31:0] rez2;
    logic [15:0] elapsed;
    logic [7:0]  mark;
    logic        running;

    int checks = 0;
    int passed = 0;

    memtest_stats #(.CLK_HZ(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .pass_pulse (pass_pulse),
        .fail_pulse (fail_pulse),
        .rez1       (rez1),
        .rez2       (rez2),
        .elapsed    (elapsed),
        .mark       (mark),
        .running    (running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One input cycle: drive at a falling edge, release at the next one.
    task automatic pulse(input logic s, input logic p, input logic p_pass, input logic p_fail);
        @(negedge clk);
        start      = s;
        stop       = p;
        pass_pulse = p_pass;
        fail_pulse = p_fail;
        @(negedge clk);
        start      = 1'b0;
        stop       = 1'b0;
        pass_pulse = 1'b0;
        fail_pulse = 1'b0;
    endtask

    initial begin
        // reset
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_rez1", rez1, 32'h0);
        chk("rst_rez2", rez2, 32'h0);
        chk("rst_elapsed", {16'h0, elapsed}, 32'h0);
        chk("rst_mark", {24'h0, mark}, 32'h0);
        chk("rst_running", {31'h0, running}, 32'h0);
        reset = 1'b0;
        pulse(0, 0, 1, 0);
        chk("idle_pass_ignored", rez1, 32'h0);

        // basic counting
        pulse(1, 0, 0, 0);
        chk("start_running", {31'h0, running}, 32'h1);
        chk("start_mark", {24'h0, mark}, 32'h20);
        pulse(0, 0, 0, 1);
        chk("first_fail_rez2", rez2, 32'h1);
        chk("first_fail_mark0", {31'h0, mark[0]}, 32'h1);
        pulse(0, 0, 1, 0);
        chk("pass_latency", rez1, 32'h1);
        repeat (9) pulse(0, 0, 1, 0);
        repeat (2) pulse(0, 0, 1, 1);
        chk("count_rez1", rez1, 32'h12);
        chk("count_rez2", rez2, 32'h3);

        // BCD carry through three digits
        pulse(1, 0, 0, 0);
        pass_pulse = 1'b1;
        repeat (999) @(negedge clk);
        pass_pulse = 1'b0;
        chk("carry_999", rez1, 32'h999);
        pulse(0, 0, 1, 0);
        chk("carry_1000", rez1, 32'h1000);

        // fail counter saturation
        @(negedge clk);
        force dut.rez2 = 32'h9999_9998;
        @(negedge clk);
        release dut.rez2;
        pulse(0, 0, 0, 1);
        chk("sat_reach", rez2, 32'h9999_9999);
        repeat (3) pulse(0, 0, 0, 1);
        chk("sat_hold", rez2, 32'h9999_9999);
        chk("sat_rez1_kept", rez1, 32'h1000);

        // timer and blink
        pulse(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("blink_%0d", i), {31'h0, mark[5]}, (i < 5) ? 32'h1 : 32'h0);
            @(negedge clk);
        end
        repeat (589) @(negedge clk);
        chk("time_0059", {16'h0, elapsed}, 32'h0059);
        @(negedge clk);
        chk("time_0100", {16'h0, elapsed}, 32'h0100);
        pulse(0, 0, 1, 1);
        chk("run_rez1", rez1, 32'h1);
        chk("run_rez2", rez2, 32'h1);

        // stop / halt
        pulse(0, 1, 0, 0);
        chk("halt_running", {31'h0, running}, 32'h0);
        chk("halt_mark", {24'h0, mark}, 32'h81);
        pass_pulse = 1'b1;
        fail_pulse = 1'b1;
        repeat (30) @(negedge clk);
        pass_pulse = 1'b0;
        fail_pulse = 1'b0;
        chk("halt_rez1", rez1, 32'h1);
        chk("halt_rez2", rez2, 32'h1);
        chk("halt_elapsed", {16'h0, elapsed}, 32'h0100);
        pulse(0, 1, 0, 0);
        chk("halt_stop_again", {24'h0, mark}, 32'h81);

        // restart with a coincident pass
        pulse(1, 0, 1, 0);
        chk("restart_rez1", rez1, 32'h0);
        chk("restart_rez2", rez2, 32'h0);
        chk("restart_elapsed", {16'h0, elapsed}, 32'h0);
        chk("restart_mark", {24'h0, mark}, 32'h20);
        chk("restart_running", {31'h0, running}, 32'h1);

        // elapsed saturation
        repeat (59989) @(negedge clk);
        chk("time_9958", {16'h0, elapsed}, 32'h9958);
        @(negedge clk);
        chk("time_9959", {16'h0, elapsed}, 32'h9959);
        repeat (200) @(negedge clk);
        chk("time_sat_hold", {16'h0, elapsed}, 32'h9959);

        // reset in the middle of a run
        pulse(0, 0, 1, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_rez1", rez1, 32'h0);
        chk("midrst_rez2", rez2, 32'h0);
        chk("midrst_elapsed", {16'h0, elapsed}, 32'h0);
        chk("midrst_mark", {24'h0, mark}, 32'h0);
        chk("midrst_running", {31'h0, running}, 32'h0);
        pulse(0, 0, 1, 0);
        chk("midrst_idle", rez1, 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
